// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data_memory port between the pipeline MEM
// stage and an auxiliary (loader/debug) requester. Each access occupies the
// port for MEM_LAT cycles. The pipeline wins ties, but a saturating wait
// counter forces the aux requester through after AUX_MAX_WAIT lost arbitrations.
module dmem_arbiter #(
    parameter int MEM_LAT      = 2,
    parameter int AUX_MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_memread,
    input  logic        pipe_memwrite,
    input  logic [31:0] pipe_addr,
    input  logic [31:0] pipe_wdata,
    output logic [31:0] pipe_rdata,
    output logic        pipe_stall,
    input  logic        aux_req,
    input  logic        aux_we,
    input  logic [31:0] aux_addr,
    input  logic [31:0] aux_wdata,
    output logic        aux_gnt,
    output logic [31:0] aux_rdata,
    output logic        aux_done,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_memread,
    output logic        mem_memwrite,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int WAIT_W = $clog2(AUX_MAX_WAIT + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_LAT - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(AUX_MAX_WAIT);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_P = 2'd1;
    localparam logic [1:0] BUSY_A = 2'd2;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [WAIT_W-1:0] wait_cnt;

    logic pipe_req;
    logic pipe_is_read;
    logic aux_elig;
    logic aux_wins;
    logic last_cycle;

    assign pipe_req     = pipe_memread | pipe_memwrite;
    // A simultaneous read+write request is treated as a pure write.
    assign pipe_is_read = pipe_memread & ~pipe_memwrite;
    // aux is masked while its done pulse is out, giving the requester time to drop.
    assign aux_elig     = aux_req & ~aux_done;
    assign aux_wins     = aux_elig & (~pipe_req | (wait_cnt == WAIT_MAX));
    assign last_cycle   = (state != IDLE) && (cnt == CNT_LAST);

    assign aux_gnt    = (state == BUSY_A);
    assign pipe_stall = pipe_req & ~((state == BUSY_P) && (cnt == CNT_LAST));
    assign pipe_rdata = ((state == BUSY_P) && last_cycle && pipe_is_read) ? mem_rdata : 32'h0;

    // Arbitration FSM, access-latency counter, aux starvation counter and aux result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            wait_cnt  <= '0;
            aux_rdata <= 32'h0;
            aux_done  <= 1'b0;
        end else begin
            aux_done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (aux_wins) begin
                        state    <= BUSY_A;
                        wait_cnt <= '0;
                    end else if (pipe_req) begin
                        state <= BUSY_P;
                        if (aux_elig && (wait_cnt != WAIT_MAX)) begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    end
                end
                BUSY_P, BUSY_A: begin
                    cnt <= cnt + CNT_W'(1);
                    if (last_cycle) begin
                        state <= IDLE;
                        cnt   <= '0;
                        if (state == BUSY_A) begin
                            aux_done <= 1'b1;
                            if (!aux_we) begin
                                aux_rdata <= mem_rdata;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Steer the granted requester onto the memory port; the port is quiet in IDLE
    // and while reset is asserted, so an aborted access never commits a write.
    always_comb begin
        mem_addr     = 32'h0;
        mem_wdata    = 32'h0;
        mem_memread  = 1'b0;
        mem_memwrite = 1'b0;
        if (!rst) begin
            if (state == BUSY_P) begin
                mem_addr     = pipe_addr;
                mem_wdata    = pipe_wdata;
                mem_memread  = pipe_is_read;
                mem_memwrite = pipe_memwrite;
            end else if (state == BUSY_A) begin
                mem_addr     = aux_addr;
                mem_wdata    = aux_wdata;
                mem_memread  = ~aux_we;
                mem_memwrite = aux_we;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table plus hand-written sequences for the
// starvation guard and reset-during-access behaviour of dmem_arbiter.
module tb_dmem_arbiter;

    typedef struct {
        logic        rst;
        logic        prd;
        logic        pwr;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic        areq;
        logic        awe;
        logic [31:0] aaddr;
        logic [31:0] awdata;
        logic        e_stall;
        logic [31:0] e_prdata;
        logic        e_gnt;
        logic        e_done;
        logic [31:0] e_ardata;
        logic        e_mrd;
        logic        e_mwr;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
    } vec_t;

    localparam logic [31:0] D = 32'hDEAD_BEEF;
    localparam logic [31:0] A = 32'h1234_5678;
    localparam logic [31:0] C = 32'hCAFE_F00D;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_memread, pipe_memwrite;
    logic [31:0] pipe_addr, pipe_wdata, pipe_rdata;
    logic        pipe_stall;
    logic        aux_req, aux_we;
    logic [31:0] aux_addr, aux_wdata, aux_rdata;
    logic        aux_gnt, aux_done;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_memread, mem_memwrite;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:63];
    logic        mem_init;
    logic        addr_ok;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_LAT(2), .AUX_MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .pipe_memread(pipe_memread), .pipe_memwrite(pipe_memwrite),
        .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
        .pipe_rdata(pipe_rdata), .pipe_stall(pipe_stall),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_gnt(aux_gnt), .aux_rdata(aux_rdata), .aux_done(aux_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .mem_rdata(mem_rdata)
    );

    // Small word-addressed data memory: asynchronous read, write on the clock edge.
    assign addr_ok   = (mem_addr[31:8] == 24'h0) && (mem_addr[1:0] == 2'b00);
    assign mem_rdata = addr_ok ? mem[mem_addr[7:2]] : 32'h0;

    // Memory contents: preload during init, otherwise commit writes from the arbiter.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4] <= D;
        end else if (mem_memwrite && addr_ok) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    function automatic vec_t vec(
        input logic rst_i, input logic prd, input logic pwr, input logic [31:0] paddr,
        input logic [31:0] pwdata, input logic areq, input logic awe, input logic [31:0] aaddr,
        input logic [31:0] awdata, input logic st, input logic [31:0] prdata, input logic gnt,
        input logic done, input logic [31:0] ardata, input logic mrd, input logic mwr,
        input logic [31:0] maddr, input logic [31:0] mwdata);
        vec_t v;
        v.rst = rst_i; v.prd = prd; v.pwr = pwr; v.paddr = paddr; v.pwdata = pwdata;
        v.areq = areq; v.awe = awe; v.aaddr = aaddr; v.awdata = awdata;
        v.e_stall = st; v.e_prdata = prdata; v.e_gnt = gnt; v.e_done = done;
        v.e_ardata = ardata; v.e_mrd = mrd; v.e_mwr = mwr; v.e_maddr = maddr; v.e_mwdata = mwdata;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst = v.rst;
        pipe_memread = v.prd; pipe_memwrite = v.pwr;
        pipe_addr = v.paddr; pipe_wdata = v.pwdata;
        aux_req = v.areq; aux_we = v.awe; aux_addr = v.aaddr; aux_wdata = v.awdata;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    vec_t tbl [0:27];
    int first_rise, second_rise, gnt_cycles, gnt_unstalled;
    int done_count, done_first, done_second, unstall_count, bad_rdata;
    logic prev_gnt;

    initial begin
        // rst prd pwr paddr pwdata | areq awe aaddr awdata || stall prdata gnt done ardata mrd mwr maddr mwdata
        tbl[0]  = vec(1,0,0,0,0,     0,0,0,0,     0,0,0,0,0, 0,0,0,0);
        tbl[1]  = vec(0,1,0,'h10,0,  0,0,0,0,     1,0,0,0,0, 0,0,0,0);
        tbl[2]  = vec(0,1,0,'h10,0,  0,0,0,0,     1,0,0,0,0, 1,0,'h10,0);
        tbl[3]  = vec(0,1,0,'h10,0,  0,0,0,0,     0,D,0,0,0, 1,0,'h10,0);
        tbl[4]  = vec(0,0,0,0,0,     0,0,0,0,     0,0,0,0,0, 0,0,0,0);
        tbl[5]  = vec(0,0,0,0,0,     1,1,'h20,A,  0,0,0,0,0, 0,0,0,0);
        tbl[6]  = vec(0,0,0,0,0,     1,1,'h20,A,  0,0,1,0,0, 0,1,'h20,A);
        tbl[7]  = vec(0,0,0,0,0,     1,1,'h20,A,  0,0,1,0,0, 0,1,'h20,A);
        tbl[8]  = vec(0,0,0,0,0,     1,1,'h20,A,  0,0,0,1,0, 0,0,0,0);
        tbl[9]  = vec(0,1,0,'h20,0,  0,0,0,0,     1,0,0,0,0, 0,0,0,0);
        tbl[10] = vec(0,1,0,'h20,0,  0,0,0,0,     1,0,0,0,0, 1,0,'h20,0);
        tbl[11] = vec(0,1,0,'h20,0,  0,0,0,0,     0,A,0,0,0, 1,0,'h20,0);
        tbl[12] = vec(0,0,0,0,0,     0,0,0,0,     0,0,0,0,0, 0,0,0,0);
        tbl[13] = vec(0,1,0,'h10,0,  1,0,'h20,0,  1,0,0,0,0, 0,0,0,0);
        tbl[14] = vec(0,1,0,'h10,0,  1,0,'h20,0,  1,0,0,0,0, 1,0,'h10,0);
        tbl[15] = vec(0,1,0,'h10,0,  1,0,'h20,0,  0,D,0,0,0, 1,0,'h10,0);
        tbl[16] = vec(0,0,0,0,0,     1,0,'h20,0,  0,0,0,0,0, 0,0,0,0);
        tbl[17] = vec(0,0,0,0,0,     1,0,'h20,0,  0,0,1,0,0, 1,0,'h20,0);
        tbl[18] = vec(0,0,0,0,0,     1,0,'h20,0,  0,0,1,0,0, 1,0,'h20,0);
        tbl[19] = vec(0,0,0,0,0,     1,0,'h20,0,  0,0,0,1,A, 0,0,0,0);
        tbl[20] = vec(0,0,0,0,0,     0,0,0,0,     0,0,0,0,A, 0,0,0,0);
        tbl[21] = vec(0,1,1,'h4,'hA5, 0,0,0,0,    1,0,0,0,A, 0,0,0,0);
        tbl[22] = vec(0,1,1,'h4,'hA5, 0,0,0,0,    1,0,0,0,A, 0,1,'h4,'hA5);
        tbl[23] = vec(0,1,1,'h4,'hA5, 0,0,0,0,    0,0,0,0,A, 0,1,'h4,'hA5);
        tbl[24] = vec(0,1,0,'h4,0,   0,0,0,0,     1,0,0,0,A, 0,0,0,0);
        tbl[25] = vec(0,1,0,'h4,0,   0,0,0,0,     1,0,0,0,A, 1,0,'h4,0);
        tbl[26] = vec(0,1,0,'h4,0,   0,0,0,0,     0,'hA5,0,0,A, 1,0,'h4,0);
        tbl[27] = vec(0,0,0,0,0,     0,0,0,0,     0,0,0,0,A, 0,0,0,0);

        mem_init = 1'b1;
        applyStimulus(tbl[0]);
        repeat (2) @(posedge clk);
        #1;
        mem_init = 1'b0;

        for (int i = 0; i < 28; i++) begin
            applyStimulus(tbl[i]);
            @(negedge clk);
            checkOutput($sformatf("v%0d pipe_stall", i),   32'(pipe_stall),   32'(tbl[i].e_stall));
            checkOutput($sformatf("v%0d pipe_rdata", i),   pipe_rdata,        tbl[i].e_prdata);
            checkOutput($sformatf("v%0d aux_gnt", i),      32'(aux_gnt),      32'(tbl[i].e_gnt));
            checkOutput($sformatf("v%0d aux_done", i),     32'(aux_done),     32'(tbl[i].e_done));
            checkOutput($sformatf("v%0d aux_rdata", i),    aux_rdata,         tbl[i].e_ardata);
            checkOutput($sformatf("v%0d mem_memread", i),  32'(mem_memread),  32'(tbl[i].e_mrd));
            checkOutput($sformatf("v%0d mem_memwrite", i), 32'(mem_memwrite), 32'(tbl[i].e_mwr));
            checkOutput($sformatf("v%0d mem_addr", i),     mem_addr,          tbl[i].e_maddr);
            checkOutput($sformatf("v%0d mem_wdata", i),    mem_wdata,         tbl[i].e_mwdata);
            @(posedge clk);
            #1;
        end
        checkOutput("mem[0x20] after aux write", mem[8], A);
        checkOutput("mem[0x4] after rd+wr store", mem[1], 32'hA5);

        // Starvation guard: pipe loads back to back, aux read held until cycle 34.
        first_rise = 0; second_rise = 0; gnt_cycles = 0; gnt_unstalled = 0;
        done_count = 0; done_first = 0; done_second = 0; unstall_count = 0; bad_rdata = 0;
        prev_gnt = 1'b0;
        for (int n = 1; n <= 36; n++) begin
            pipe_memread = 1'b1; pipe_memwrite = 1'b0; pipe_addr = 32'h10; pipe_wdata = 32'h0;
            aux_req = (n <= 34); aux_we = 1'b0; aux_addr = 32'h20; aux_wdata = 32'h0;
            @(negedge clk);
            if (aux_gnt) begin
                gnt_cycles++;
                if (!pipe_stall) gnt_unstalled++;
                if (!prev_gnt) begin
                    if (first_rise == 0) first_rise = n;
                    else if (second_rise == 0) second_rise = n;
                end
            end
            if (aux_done) begin
                done_count++;
                if (done_first == 0) done_first = n;
                else done_second = n;
            end
            if (!pipe_stall) begin
                unstall_count++;
                if (pipe_rdata !== D) bad_rdata++;
            end
            prev_gnt = aux_gnt;
            @(posedge clk);
            #1;
        end
        checkOutput("starve first aux grant cycle",  first_rise,    14);
        checkOutput("starve second aux grant cycle", second_rise,   32);
        checkOutput("starve aux grant cycles",       gnt_cycles,    4);
        checkOutput("starve unstalled during grant", gnt_unstalled, 0);
        checkOutput("starve done pulses",            done_count,    2);
        checkOutput("starve first done cycle",       done_first,    16);
        checkOutput("starve second done cycle",      done_second,   34);
        checkOutput("starve pipe unstalled cycles",  unstall_count, 10);
        checkOutput("starve bad pipe_rdata",         bad_rdata,     0);

        // Reset in the first cycle of an aux write: access aborted, no done, memory untouched.
        pipe_memread = 1'b0; pipe_memwrite = 1'b0; pipe_addr = 32'h0;
        aux_req = 1'b1; aux_we = 1'b1; aux_addr = 32'h30; aux_wdata = C;
        @(negedge clk);
        checkOutput("rst-seq aux_rdata before", aux_rdata, A);
        checkOutput("rst-seq aux_gnt idle", 32'(aux_gnt), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1; aux_req = 1'b0;
        @(negedge clk);
        checkOutput("rst-seq aux_gnt busy", 32'(aux_gnt), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checkOutput($sformatf("rst-seq c%0d aux_gnt", k),      32'(aux_gnt),      32'h0);
            checkOutput($sformatf("rst-seq c%0d aux_done", k),     32'(aux_done),     32'h0);
            checkOutput($sformatf("rst-seq c%0d aux_rdata", k),    aux_rdata,         32'h0);
            checkOutput($sformatf("rst-seq c%0d mem_memwrite", k), 32'(mem_memwrite), 32'h0);
            checkOutput($sformatf("rst-seq c%0d mem_addr", k),     mem_addr,          32'h0);
            checkOutput($sformatf("rst-seq c%0d pipe_stall", k),   32'(pipe_stall),   32'h0);
            @(posedge clk);
            #1;
        end
        checkOutput("rst-seq mem[0x30] unchanged", mem[12], 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
